// File: rtl/fetch_stage_pkg.sv
// Shared fetch-stage constants: PC select codes, NOP word, FSM encoding.
// Imported by the fetch interface, PC generator and stage top.
package fetch_stage_pkg;

  localparam logic [31:0] RESET_PC = 32'h4000_0000;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  localparam logic [1:0] PCSEL_PLUS4 = 2'd0;
  localparam logic [1:0] PCSEL_ALU   = 2'd1;

  typedef enum logic [1:0] {
    FETCH_BOOT,
    FETCH_RUN,
    FETCH_MISS,
    FETCH_PEND
  } fetch_state_e;

  function automatic logic [31:0] align_pc(
    input logic [31:0] a
  );
    return a & ~32'h3;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-cache port between the fetch stage and the I-cache.
// Fetch side is the master; it owns address and read enable.
interface fetch_stage_if;

  logic [31:0] icache_addr;
  logic        icache_re;
  logic [31:0] icache_dout;
  logic        icache_stall;

  modport master (
    output icache_addr,
    output icache_re,
    input  icache_dout,
    input  icache_stall
  );

  modport slave (
    input  icache_addr,
    input  icache_re,
    output icache_dout,
    output icache_stall
  );

endinterface

// File: rtl/fetch_pc_gen.sv
// Next fetch address mux: reset/boot, stall hold, miss hold,
// pending redirect, kill redirect, sequential +4.
module fetch_pc_gen
  import fetch_stage_pkg::*;
(
  input  logic         reset,
  input  fetch_state_e state,
  input  logic         stall,
  input  logic         icache_stall,
  input  logic         inst_kill,
  input  logic [1:0]   pc_sel,
  input  logic [31:0]  alu_target,
  input  logic [31:0]  pc_f,
  input  logic [31:0]  pend_pc,
  output logic [31:0]  next_addr
);

  logic [31:0] pc_plus4;
  logic        redirect;

  assign pc_plus4 = pc_f + 32'd4;
  assign redirect = inst_kill
                 && (pc_sel == PCSEL_ALU);

  always_comb begin
    next_addr = pc_plus4;
    if (reset || state == FETCH_BOOT)
      next_addr = RESET_PC;
    else if (stall || icache_stall)
      next_addr = pc_f;
    else if (state == FETCH_PEND)
      next_addr = pend_pc;
    else if (redirect)
      next_addr = align_pc(alu_target);
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, drives the I-cache, applies
// redirects/kills and substitutes NOPs for missing or killed words.
module fetch_stage
  import fetch_stage_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic [1:0]   PC_Sel,
  input  logic         Inst_Kill,
  input  logic [31:0]  alu_target,
  input  logic         stall,
  fetch_stage_if.master icache,
  output logic [31:0]  inst,
  output logic [31:0]  inst_pc,
  output logic         inst_valid
);

  fetch_state_e state;
  logic [31:0]  pc_f;
  logic [31:0]  pend_pc;
  logic [31:0]  next_addr;
  logic         kill;
  logic         take;

  fetch_pc_gen u_pc_gen (
    .reset        (reset),
    .state        (state),
    .stall        (stall),
    .icache_stall (icache.icache_stall),
    .inst_kill    (Inst_Kill),
    .pc_sel       (PC_Sel),
    .alu_target   (alu_target),
    .pc_f         (pc_f),
    .pend_pc      (pend_pc),
    .next_addr    (next_addr)
  );

  assign icache.icache_addr = next_addr;
  assign icache.icache_re   = !reset;

  // A kill under a global stall is ignored; control re-asserts it.
  assign kill = Inst_Kill && !stall;
  assign take = !reset && !kill
             && !icache.icache_stall
             && (state == FETCH_RUN
              || state == FETCH_MISS);

  assign inst       = take ? icache.icache_dout
                           : NOP_INST;
  assign inst_valid = take;
  assign inst_pc    = reset ? RESET_PC : pc_f;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= FETCH_BOOT;
      pc_f    <= RESET_PC;
      pend_pc <= RESET_PC;
    end else if (!stall) begin
      pc_f <= next_addr;
      unique case (state)
        FETCH_BOOT: state <= FETCH_RUN;
        FETCH_RUN,
        FETCH_MISS: begin
          if (icache.icache_stall) begin
            state <= Inst_Kill ? FETCH_PEND
                               : FETCH_MISS;
            if (Inst_Kill)
              pend_pc <= align_pc(alu_target);
          end else begin
            state <= FETCH_RUN;
          end
        end
        FETCH_PEND: begin
          if (!icache.icache_stall)
            state <= FETCH_RUN;
        end
      endcase
    end
  end

endmodule
